// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM port arbiter.
package sdram_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 10;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_ISSUE     = 3'd1;
    localparam state_t ST_WAIT_DONE = 3'd2;
    localparam state_t ST_WAIT_LOW  = 3'd3;
    localparam state_t ST_ACK       = 3'd4;

    // Request payload captured from a requester at grant time.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single level crossing into the arbiter clock.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller port: grants one
// requester, issues one read/write pulse, waits for completion, acks.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned P0_PRIORITY = 0
) (
    input  logic              CLOCK_100_del_3ns,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ctl_address,
    output logic              ctl_req_read,
    output logic              ctl_req_write,
    output logic [DATA_W-1:0] ctl_data_in,
    input  logic [DATA_W-1:0] ctl_data_out,
    input  logic              ctl_data_valid,
    input  logic              ctl_write_complete,
    output logic              busy
);

    state_t            state, state_nx;
    logic              dv_s, wc_s;
    logic              gnt, we_q, last_grant;
    logic [CNT_W-1:0]  cnt;

    logic              gnt_d, we_d, last_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata0_d, rdata1_d;
    logic              rd_d, wr_d, ack0_d, ack1_d, err0_d, err1_d, busy_d;

    req_t              p0_pl, p1_pl, sel_pl;
    logic              sel_c, done_c, tmo_c, any_req_c;

    // Completion levels come from the controller's slower clock domain.
    sync2 u_sync_dv (.clk(CLOCK_100_del_3ns), .rst(rst), .d(ctl_data_valid),     .q(dv_s));
    sync2 u_sync_wc (.clk(CLOCK_100_del_3ns), .rst(rst), .d(ctl_write_complete), .q(wc_s));

    assign p0_pl     = {p0_we, p0_addr, p0_wdata};
    assign p1_pl     = {p1_we, p1_addr, p1_wdata};
    assign any_req_c = p0_req || p1_req;
    // Tie goes to the port that did not win last time unless port 0 has priority.
    assign sel_c     = (p0_req && p1_req) ? ((P0_PRIORITY != 0) ? PORT_CPU : ~last_grant) : p1_req;
    assign sel_pl    = sel_c ? p1_pl : p0_pl;
    assign done_c    = we_q ? wc_s : dv_s;
    assign tmo_c     = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge CLOCK_100_del_3ns) begin
        if (rst) begin
            state         <= ST_IDLE;
            gnt           <= PORT_CPU;
            we_q          <= 1'b0;
            last_grant    <= PORT_DMA;
            cnt           <= '0;
            ctl_address   <= '0;
            ctl_data_in   <= '0;
            ctl_req_read  <= 1'b0;
            ctl_req_write <= 1'b0;
            p0_ack        <= 1'b0;
            p0_err        <= 1'b0;
            p0_rdata      <= '0;
            p1_ack        <= 1'b0;
            p1_err        <= 1'b0;
            p1_rdata      <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            gnt           <= gnt_d;
            we_q          <= we_d;
            last_grant    <= last_d;
            cnt           <= cnt_d;
            ctl_address   <= addr_d;
            ctl_data_in   <= wdata_d;
            ctl_req_read  <= rd_d;
            ctl_req_write <= wr_d;
            p0_ack        <= ack0_d;
            p0_err        <= err0_d;
            p0_rdata      <= rdata0_d;
            p1_ack        <= ack1_d;
            p1_err        <= err1_d;
            p1_rdata      <= rdata1_d;
            busy          <= busy_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (any_req_c) state_nx = ST_ISSUE;
            ST_ISSUE:     state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done_c || tmo_c) state_nx = ST_ACK;
            ST_ACK:       state_nx = ST_WAIT_LOW;
            // A completion level still high must not finish the next transaction.
            ST_WAIT_LOW:  if (!dv_s && !wc_s) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = gnt;
        we_d     = we_q;
        last_d   = last_grant;
        cnt_d    = cnt;
        addr_d   = ctl_address;
        wdata_d  = ctl_data_in;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = p0_rdata;
        rdata1_d = p1_rdata;
        busy_d   = (state_nx != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (any_req_c) begin
                    gnt_d   = sel_c;
                    we_d    = sel_pl.we;
                    addr_d  = sel_pl.addr;
                    wdata_d = sel_pl.wdata;
                    rd_d    = !sel_pl.we;
                    wr_d    = sel_pl.we;
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT_DONE: begin
                cnt_d = cnt + CNT_W'(1);
                // Completion in the timeout cycle still counts as success.
                if (done_c || tmo_c) begin
                    ack0_d = (gnt == PORT_CPU);
                    ack1_d = (gnt == PORT_DMA);
                    err0_d = !done_c && (gnt == PORT_CPU);
                    err1_d = !done_c && (gnt == PORT_DMA);
                    if (done_c && !we_q) begin
                        if (gnt == PORT_CPU) rdata0_d = ctl_data_out;
                        else                 rdata1_d = ctl_data_out;
                    end
                end
            end
            ST_ACK: last_d = gnt;
            default: ;
        endcase
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: port 0 (CPU) and port 1 (video/DMA fetch).
- Latches each requester's level-held request, picks a winner by round-robin, and issues exactly one single-cycle read or write pulse to the controller.
- Waits for the controller's completion level, returns read data with a one-cycle ack, then re-arms for the next request.
- Sits between the d16 bus/DMA logic and the SDRAM controller.

Parameters:
- TIMEOUT, 255: cycles allowed from issue to completion before the transaction is aborted with an error; range 1..1023.
- P0_PRIORITY, 0: 1 = port 0 always wins a tie; 0 = round-robin.

Ports:
- CLOCK_100_del_3ns  in  1  block clock
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  request; held high until p0_ack
- p0_we  in  1  1 = write, 0 = read; sampled at grant
- p0_addr  in  24  word address; sampled at grant
- p0_wdata  in  32  write data; sampled at grant
- p0_ack  out  1  one-cycle completion pulse
- p0_err  out  1  valid with p0_ack; 1 = timeout
- p0_rdata  out  32  read data; valid with p0_ack
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0
- ctl_address  out  24  to controller address
- ctl_req_read  out  1  single-cycle read pulse
- ctl_req_write  out  1  single-cycle write pulse
- ctl_data_in  out  32  to controller write data
- ctl_data_out  in  32  controller read data
- ctl_data_valid  in  1  read completion level (CLOCK_50 domain)
- ctl_write_complete  in  1  write completion level (CLOCK_50 domain)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 on a clock edge):
  - state=IDLE, last_grant=1 (so port 0 wins first).
  - All outputs 0: acks, errs, rdata, ctl_* outputs, busy.
  - Timeout counter cleared.
- Input synchronisation: ctl_data_valid and ctl_write_complete each pass through a 2-flop synchroniser. Only the synchronised copies (dv_s, wc_s) are used.
- FSM states: IDLE, ISSUE, WAIT_DONE, WAIT_LOW, ACK.
- IDLE:
  - If any req is high, grant one. With P0_PRIORITY=0 the grant goes to the port not in last_grant; a single requester is granted directly.
  - At grant: latch gnt, we, addr, wdata into ctl_address / ctl_data_in; go to ISSUE.
- ISSUE (1 cycle):
  - Assert ctl_req_write if we, else ctl_req_read, for exactly this cycle.
  - Clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - Increment the timeout counter each cycle.
  - Done when (we & wc_s) or (!we & dv_s). On done: capture ctl_data_out (reads only) into the granted port's rdata register; go to ACK.
  - If the counter reaches TIMEOUT first: set err for the granted port; go to ACK.
  - Done and timeout in the same cycle: done wins, err=0.
- ACK (1 cycle):
  - Pulse the granted port's ack (and err if set); update last_grant = gnt.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Stay until both dv_s and wc_s are 0, then go to IDLE.
  - This prevents a stale completion level from completing the next transaction.
  - A timeout path also passes through WAIT_LOW.
- rdata holding:
  - p*_rdata holds its value until that port's next read ack.
  - Write acks leave rdata unchanged.
- Request changes after grant: ignored. The latched address and data are used. A requester that drops req before ack still receives the ack.
- Both requests high in IDLE: one grant only. The loser stays pending and is granted on the next IDLE visit (round-robin guarantees alternation).
- Minimum request-to-ack latency: 3 cycles + controller latency + 2 synchroniser cycles.
- Reset mid-transaction: return to IDLE immediately, no ack issued. The controller's own pending flag is the controller's responsibility, since its reset is shared.
- ctl_req_read and ctl_req_write are never high together and never high outside ISSUE.

Decomposition:
- Shared package sdram_pkg:
  - FSM state encodings (3-bit localparams).
  - Port index constants PORT_CPU=0, PORT_DMA=1.
  - SDRAM address width 24 and data width 32.
- One sub-module: sync2 (2-flop synchroniser, 1-bit, reset to 0), instantiated twice.

Test Plan:
- Port 0 write, addr 0x000123, data 0xDEADBEEF; model raises wc 10 cycles after pulse -> exactly one ctl_req_write pulse with ctl_address=0x000123 and ctl_data_in=0xDEADBEEF; one p0_ack with p0_err=0.
- Port 1 read, addr 0x00ABCD; model returns 0x12345678 with dv -> p1_ack pulse with p1_rdata=0x12345678; p0_ack stays 0.
- p0_req and p1_req high together from reset, each re-asserted after ack -> grant order 0,1,0,1; never two ctl pulses without an intervening ack.
- Model holds dv high for 20 cycles after a read; next request already pending -> second ctl pulse appears only after dv_s falls.
- Model never completes, TIMEOUT=16 -> p0_ack and p0_err pulse together 17–18 cycles after ISSUE; next request is still serviced.
- rst asserted during WAIT_DONE -> next cycle state IDLE and all outputs 0; no ack emitted for the aborted transaction.
